// File: rtl/skid_register_pkg.sv
// Shared types for the skid_register elastic pipeline stage.
// Holds the occupancy encoding used by the top and any future wrappers.
package skid_register_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/skid_register.sv
// Two-entry valid/ready skid register with a fully registered in_ready.
// Optional synchronous flush port is built when SKID_REGISTER_FLUSH_EN is defined.
module skid_register
    import skid_register_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef SKID_REGISTER_FLUSH_EN
    ,
    input  logic             flush
`endif
);

    skid_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             in_xfer, out_xfer;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_ready  = in_ready_q;

    // in_ready_q is zero while FULL, so in_xfer never fires in that state.
    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = in_data;
                end else if (in_xfer) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
`ifdef SKID_REGISTER_FLUSH_EN
        // Only occupancy is dropped; the data registers keep stale contents.
        if (flush) begin
            state_d = EMPTY;
        end
`endif
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_skid_register.sv
// Self-checking bench for skid_register against a queue-based occupancy model.
// Exercises the flush scenario too when SKID_REGISTER_FLUSH_EN is defined.
module tb_skid_register;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;
`ifdef SKID_REGISTER_FLUSH_EN
    logic         flush = 1'b0;
`endif

    int compared = 0;
    int mismatched = 0;

    // Reference: an ordered list of held beats (capacity two) plus the expected in_ready.
    logic [W-1:0] mq[$];
    bit           m_ready = 1'b0;

    skid_register #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef SKID_REGISTER_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock edge and update the reference; returns on the next falling edge.
    task automatic step();
        bit           do_in;
        bit           do_out;
        logic [W-1:0] d;
        do_in  = in_valid && m_ready;
        do_out = out_ready && (mq.size() > 0);
        d      = in_data;
        @(posedge clk);
        if (do_out) void'(mq.pop_front());
`ifdef SKID_REGISTER_FLUSH_EN
        if (flush) begin
            mq.delete();
            do_in = 1'b0;
        end
`endif
        if (do_in) mq.push_back(d);
        m_ready = (mq.size() < 2);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        mq.delete();
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        compared++;
        if (out_data !== '0) begin
            mismatched++;
            $display("FAIL reset_out_data: got %h want 0", out_data);
        end
        compared++;
        if (in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        reset_n = 1'b1;
        #1;
        compared++;
        if (in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL release_in_ready_before_edge: got %b want 0", in_ready);
        end
        @(negedge clk);
        step();
        compared++;
        if (in_ready !== m_ready) begin
            mismatched++;
            $display("FAIL release_in_ready_after_edge: got %b want %b", in_ready, m_ready);
        end
        $display("reset: done, in_ready=%b", in_ready);
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            step();
            compared++;
            if (out_valid !== 1'b1 || out_data !== W'(i)) begin
                mismatched++;
                $display("FAIL stream_out: got v=%b d=%h want v=1 d=%h", out_valid, out_data, W'(i));
            end
            compared++;
            if (in_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL stream_in_ready: got %b want 1", in_ready);
            end
            $display("stream: beat %0d out_data=%h", i, out_data);
        end
        in_valid = 1'b0;
        step();
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL stream_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        step();
        in_data = 32'hB;
        step();
        in_valid = 1'b0;
        in_data  = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            compared++;
            if (out_valid !== 1'b1 || out_data !== 32'hA || in_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL bp_full_hold: got v=%b d=%h rdy=%b want v=1 d=a rdy=0",
                         out_valid, out_data, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        compared++;
        if (out_valid !== 1'b1 || out_data !== 32'hB || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_second: got v=%b d=%h rdy=%b want v=1 d=b rdy=1",
                     out_valid, out_data, in_ready);
        end
        step();
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_drain: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        $display("backpressure: a then b delivered");
    endtask

    task automatic test_random_stall();
        logic [W-1:0] got[$];
        int           next_val;
        int           cycles;
        int           bad_idx;
        next_val = 0;
        cycles   = 0;
        while (got.size() < 100 && cycles < 3000) begin
            compared++;
            if (out_valid !== (mq.size() > 0) || in_ready !== m_ready ||
                (mq.size() > 0 && out_data !== mq[0])) begin
                mismatched++;
                $display("FAIL stall_cycle%0d: got v=%b d=%h rdy=%b want v=%b d=%h rdy=%b",
                         cycles, out_valid, out_data, in_ready, mq.size() > 0,
                         (mq.size() > 0) ? mq[0] : '0, m_ready);
            end
            in_valid  = (next_val < 100) && ($urandom_range(0, 3) != 0);
            in_data   = in_valid ? W'(next_val) : W'($urandom);
            out_ready = ($urandom_range(0, 1) == 1);
            if (out_valid && out_ready) got.push_back(out_data);
            if (in_valid && m_ready) next_val++;
            step();
            cycles++;
        end
        in_valid = 1'b0;
        compared++;
        if (got.size() != 100) begin
            mismatched++;
            $display("FAIL stall_count: got %0d beats want 100", got.size());
        end
        bad_idx = -1;
        for (int i = 0; i < got.size(); i++) begin
            if (bad_idx < 0 && got[i] !== W'(i)) bad_idx = i;
        end
        compared++;
        if (bad_idx >= 0) begin
            mismatched++;
            $display("FAIL stall_order: index %0d got %h want %h", bad_idx, got[bad_idx], W'(bad_idx));
        end
        $display("random_stall: %0d beats in %0d cycles", got.size(), cycles);
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'($urandom);
        step();
        in_data = W'($urandom);
        step();
        in_valid = 1'b0;
        compared++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || mq.size() != 2) begin
            mismatched++;
            $display("FAIL arst_prefill: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
        end
        #2;
        reset_n = 1'b0;
        #1;
        mq.delete();
        m_ready = 1'b0;
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== '0) begin
            mismatched++;
            $display("FAIL arst_immediate: got v=%b rdy=%b d=%h want v=0 rdy=0 d=0",
                     out_valid, in_ready, out_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL arst_recover: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        $display("async_reset: entries dropped");
    endtask

`ifdef SKID_REGISTER_FLUSH_EN
    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
        in_data = 32'h22;
        step();
        in_data = 32'hC;
        flush   = 1'b1;
        step();
        flush = 1'b0;
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL flush_empty: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        in_data   = 32'hD;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        compared++;
        if (out_valid !== 1'b1 || out_data !== 32'hD) begin
            mismatched++;
            $display("FAIL flush_next: got v=%b d=%h want v=1 d=d", out_valid, out_data);
        end
        step();
        compared++;
        if (out_valid !== (mq.size() > 0)) begin
            mismatched++;
            $display("FAIL flush_drain: got v=%b want %b", out_valid, mq.size() > 0);
        end
        $display("flush: c dropped, d delivered");
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_random_stall();
        test_async_reset();
`ifdef SKID_REGISTER_FLUSH_EN
        test_flush();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
